// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_e   : controller state encoding (IDLE / RUN / DONE)
//   - DEFAULT_W : default operand/result width
//   - signed_ovf: signed-overflow rule for a - b, reused wherever the flag
//                 has to be derived from the operand and result sign bits
// -----------------------------------------------------------------------------
package serial_pkg;

    // Controller states. The encoding is fixed so that a state value read
    // from a debug probe can be matched directly against this table.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Default operand/result width.
    localparam int DEFAULT_W = 8;

    // Signed overflow of a - b. Subtraction can only overflow when the
    // operands have different signs. It overflows when the result sign then
    // differs from the minuend sign.
    function automatic logic signed_ovf(
        input logic a_sign,
        input logic b_sign,
        input logic d_sign
    );
        return (a_sign != b_sign) && (d_sign != a_sign);
    endfunction

endpackage : serial_pkg

// File: rtl/serial_sub_fs.sv
// -----------------------------------------------------------------------------
// fs
//   One-bit full subtractor: computes x - y - z.
//   Ports:
//     x  : minuend bit
//     y  : subtrahend bit
//     z  : borrow in
//     d  : difference bit
//     bo : borrow out
// -----------------------------------------------------------------------------
module fs (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    // A borrow is needed when the bits taken away (y plus the incoming borrow)
    // exceed x.
    assign bo = (~x & y) | (~x & z) | (y & z);

endmodule : fs

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial W-bit subtractor. It computes d = a - b one bit per clock,
//   starting with the LSB. A single borrow flop carries the borrow from one
//   bit to the next. Only one operation is in flight at a time. Input and
//   output each use a valid/ready handshake.
//
//   Timing: operands are accepted at edge 0. Bits 0..W-1 are produced on
//   edges 1..W. The result and flags are latched on edge W, so out_valid is
//   high from edge W onward. The result is held until out_valid && out_ready.
//   in_ready rises on the cycle after that handshake. This gives at most one
//   operation every W+2 cycles.
//
//   Parameters:
//     W : operand/result width (W >= 2)
//   Ports:
//     clk       : clock; all state updates on posedge
//     rst       : synchronous reset, active-high
//     in_valid  : a/b valid
//     in_ready  : block can accept operands (high only in IDLE)
//     a         : minuend (unsigned or two's complement)
//     b         : subtrahend
//     out_valid : d and flags valid
//     out_ready : consumer accepts result
//     d         : a - b mod 2^W
//     bout      : final borrow (a < b unsigned)
//     ovf       : signed overflow
//     zero      : d == 0
// -----------------------------------------------------------------------------
module serial_sub
    import serial_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    // Bit counter. It only ever needs to reach W-1.
    localparam int            CW       = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    state_e        state_q,    state_d;
    logic [W-1:0]  a_sh_q,     a_sh_d;
    logic [W-1:0]  b_sh_q,     b_sh_d;
    logic [W-1:0]  d_sh_q,     d_sh_d;
    logic          borrow_q,   borrow_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic          a_sign_q,   a_sign_d;
    logic          b_sign_q,   b_sign_d;

    // Output registers. These are kept separate from d_sh so that d does
    // not ripple while the next operation is shifting.
    logic [W-1:0]  d_q,        d_d;
    logic          bout_q,     bout_d;
    logic          ovf_q,      ovf_d;
    logic          zero_q,     zero_d;

    // ---------------------------------------------------------------------
    // Per-bit cell: operates on the current LSB of each shift register
    // ---------------------------------------------------------------------
    logic fs_di;
    logic fs_bo;

    fs fs0 (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .z  (borrow_q),
        .d  (fs_di),
        .bo (fs_bo)
    );

    // The difference bit for this edge enters at the top of the shift
    // register. After W shifts, the LSB has reached bit 0.
    logic [W-1:0] d_shifted;
    assign d_shifted = {fs_di, d_sh_q[W-1:1]};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone
                // completes the input handshake.
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    a_sign_d = a[W-1];
                    b_sign_d = b[W-1];
                    state_d  = RUN;
                end
            end

            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                d_sh_d   = d_shifted;
                borrow_d = fs_bo;
                if (cnt_q == CNT_LAST) begin
                    // Last bit. Latch the result and flags straight from
                    // this edge's cell outputs, so they are visible at the
                    // same time as out_valid.
                    cnt_d   = '0;
                    state_d = DONE;
                    d_d     = d_shifted;
                    bout_d  = fs_bo;
                    ovf_d   = signed_ovf(a_sign_q, b_sign_q, fs_di);
                    zero_d  = (d_shifted == '0);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers. Reset takes priority over every other input.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Both handshake outputs are decoded directly from the state register,
    // so they are glitch-free and change only at clock edges.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
//   Directed bench for serial_sub with W=8. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    serial_sub #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A full operation with out_ready held high. It checks the latency, the
    // result, and the return to IDLE after the handshake.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        tick();                               // accept edge 0
        in_valid = 1'b0;
        check({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
        for (int i = 1; i < W; i++) tick();   // edges 1..W-1
        check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        tick();                               // edge W
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".d"},    32'(d),    32'(ed));
        check({tag, ".bout"}, 32'(bout), 32'(eb));
        check({tag, ".ovf"},  32'(ovf),  32'(eo));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        tick();                               // handshake edge
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(in_ready),  32'd1);
        check({tag, ".d_held"},     32'(d),         32'(ed));
        $display("op %s a=%02h b=%02h d=%02h bout=%0b ovf=%0b zero=%0b", tag, av, bv, d, bout, ovf, zero);
    endtask

    initial begin
        bit seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.d",    32'(d),    32'd0);
        check("rst.bout", 32'(bout), 32'd0);
        check("rst.ovf",  32'(ovf),  32'd0);
        check("rst.zero", 32'(zero), 32'd0);

        run_op("5-3",   8'd5,   8'd3,   8'h02, 1'b0, 1'b0, 1'b0);
        run_op("3-5",   8'd3,   8'd5,   8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("80-01", 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("7F-FF", 8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1, 1'b0);

        // Equal operands under back-pressure.
        a = 8'hA5; b = 8'hA5; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        check("eq.out_valid", 32'(out_valid), 32'd1);
        check("eq.d",    32'(d),    32'h00);
        check("eq.zero", 32'(zero), 32'd1);
        check("eq.bout", 32'(bout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready",  32'(in_ready),  32'd0);
            check("bp.d",    32'(d),    32'h00);
            check("bp.zero", 32'(zero), 32'd1);
            check("bp.bout", 32'(bout), 32'd0);
            check("bp.ovf",  32'(ovf),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp.release", 32'(out_valid), 32'd0);
        $display("op A5-A5 backpressure d=%02h zero=%0b", d, zero);

        // Reset asserted at the 3rd RUN edge.
        a = 8'h40; b = 8'h11; in_valid = 1'b1;
        tick();                 // accept
        in_valid = 1'b0;
        tick(); tick();         // RUN edges 1, 2
        rst = 1'b1;
        tick();                 // RUN edge 3 is the reset edge
        rst = 1'b0;
        check("mrst.in_ready",  32'(in_ready),  32'd1);
        check("mrst.out_valid", 32'(out_valid), 32'd0);
        check("mrst.d",         32'(d),         32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("mrst.no_result", 32'(seen_valid), 32'd0);
        $display("op midrun-reset in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // in_valid held high across two operations. Operand changes during
        // RUN must be ignored.
        a = 8'd10; b = 8'd4; in_valid = 1'b1; out_ready = 1'b1;
        tick();                 // accept first
        a = 8'hFF; b = 8'h00;   // garbage while RUN
        for (int i = 0; i < W; i++) tick();
        check("b2b.valid1", 32'(out_valid), 32'd1);
        check("b2b.d1",     32'(d),         32'd6);
        a = 8'd20; b = 8'd7;
        tick();                 // output handshake; no accept on this edge
        check("b2b.hs_ready", 32'(in_ready),  32'd1);
        check("b2b.hs_valid", 32'(out_valid), 32'd0);
        tick();                 // second accept
        in_valid = 1'b0;
        check("b2b.accept2", 32'(in_ready), 32'd0);
        check("b2b.d_hold",  32'(d),        32'd6);
        for (int i = 0; i < W; i++) tick();
        check("b2b.valid2", 32'(out_valid), 32'd1);
        check("b2b.d2",     32'(d),         32'd13);
        check("b2b.bout2",  32'(bout),      32'd0);
        tick();
        $display("op back-to-back second d=%02h", d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_sub
